// File: rtl/nf_mem_arb_pkg.sv
// Shared definitions for the CPU memory arbiter: FSM state encoding, default
// memory word-address width and the latched request record.
package nf_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } req_t;

endpackage

// File: rtl/nf_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module nf_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    o_grant = 1'b0;
    o_valid = |i_req;
    if (i_req == 2'b11) begin
      o_grant = ~i_last_grant;
    end else if (i_req == 2'b10) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/nf_mem_arb.sv
// Arbitrates two requesters onto one single-port synchronous memory; each
// transaction runs IDLE -> ACC -> RESP in exactly three cycles.
module nf_mem_arb
  import nf_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  input  logic              m0_we,
  input  logic [31:0]       m0_wd,
  output logic              m0_ack,
  output logic [31:0]       m0_rd,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  input  logic              m1_we,
  input  logic [31:0]       m1_wd,
  output logic              m1_ack,
  output logic [31:0]       m1_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [31:0]       r_mem_wd;

  logic              w_grant;
  logic              w_valid;
  req_t              w_sel;

  nf_rr_arb2 u_rr (
    .i_req        ({m1_req, m0_req}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_comb begin
    w_sel = w_grant ? '{addr: m1_addr, we: m1_we, wd: m1_wd}
                    : '{addr: m0_addr, we: m0_we, wd: m0_wd};
  end

  // NOTE: non-blocking assignments, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wd     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_sel.we;
            r_mem_addr   <= w_sel.addr[ADDR_W+1:2];
            r_mem_wd     <= w_sel.wd;
            r_mem_we     <= w_sel.we;
            r_state      <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_m0_ack <= ~r_owner;
          r_m1_ack <= r_owner;
          r_state  <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_we   = r_mem_we;
  assign mem_wd   = r_mem_wd;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;

  // Read data arrives from the memory during RESP, so it is steered by the
  // registered ack/we rather than re-registered (which would cost a cycle).
  assign m0_rd = (r_m0_ack && !r_we) ? mem_rd : 32'd0;
  assign m1_rd = (r_m1_ack && !r_we) ? mem_rd : 32'd0;

endmodule

// File: tb/tb_nf_mem_arb.sv
// Self-checking bench for nf_mem_arb: directed scenarios followed by random
// two-requester traffic, all checked against a transaction-level model.
module tb_nf_mem_arb;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetn;
  logic              m0_req, m0_we, m0_ack;
  logic [31:0]       m0_addr, m0_wd, m0_rd;
  logic              m1_req, m1_we, m1_ack;
  logic [31:0]       m1_addr, m1_wd, m1_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wd, mem_rd;

  always #5 clk = ~clk;

  nf_mem_arb #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_we    (m0_we),
    .m0_wd    (m0_wd),
    .m0_ack   (m0_ack),
    .m0_rd    (m0_rd),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_we    (m1_we),
    .m1_wd    (m1_wd),
    .m1_ack   (m1_ack),
    .m1_rd    (m1_rd),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  // Synchronous single-port memory device attached to the arbiter.
  logic [31:0] dev_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) dev_mem[mem_addr] <= mem_wd;
    mem_rd <= dev_mem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: phase counts cycles since grant
  // (0 = free to arbitrate, 1 = memory access, 2 = response).
  int          ph = 0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_exp_rd = '0;
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          ack_owner [$];
  int          ack_cyc [$];
  int          st [2];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic tick();
    bit rst;
    rst = resetn;
    if (rst) begin
      if (ph == 1 && m_we) ref_mem[widx(m_addr)] = m_wd;
      ph     = 0;
      m_last = 1'b1;
    end else if (ph == 0) begin
      if (m0_req || m1_req) begin
        m_owner = (m0_req && m1_req) ? !m_last : m1_req;
        m_last  = m_owner;
        m_addr  = m_owner ? m1_addr : m0_addr;
        m_we    = m_owner ? m1_we : m0_we;
        m_wd    = m_owner ? m1_wd : m0_wd;
        ph      = 1;
      end
    end else if (ph == 1) begin
      if (m_we) begin
        ref_mem[widx(m_addr)] = m_wd;
        m_exp_rd = '0;
      end else begin
        m_exp_rd = ref_mem[widx(m_addr)];
      end
      ph = 2;
    end else begin
      ph = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
    end
    check("mem_we", 32'(mem_we), 32'(ph == 1 && m_we));
    if (ph == 1) begin
      check("mem_addr", 32'(mem_addr), 32'(widx(m_addr)));
      check("mem_wd", mem_wd, m_wd);
    end
    check("m0_ack", 32'(m0_ack), 32'(ph == 2 && !m_owner));
    check("m1_ack", 32'(m1_ack), 32'(ph == 2 && m_owner));
    check("m0_rd", m0_rd, (ph == 2 && !m_owner) ? m_exp_rd : 32'd0);
    check("m1_rd", m1_rd, (ph == 2 && m_owner) ? m_exp_rd : 32'd0);
    if (ph == 2) begin
      ack_owner.push_back(int'(m_owner));
      ack_cyc.push_back(cyc);
    end
  endtask

  task automatic drive(input int i, input bit r, input logic [31:0] a,
                       input bit w, input logic [31:0] d);
    if (i == 0) begin
      m0_req = r; m0_addr = a; m0_we = w; m0_wd = d;
    end else begin
      m1_req = r; m1_addr = a; m1_we = w; m1_wd = d;
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      ref_mem[k] = $urandom;
      dev_mem[k] = ref_mem[k];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    dev_mem[4] = 32'hDEAD_BEEF;
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    resetn = 1'b1;
    tick();
    tick();
    resetn = 1'b0;

    // Lone m0 read: address in ACC, ack and data two cycles after grant.
    drive(0, 1'b1, 32'h0000_0010, 1'b0, '0);
    tick();
    check("r27_addr", 32'(mem_addr), 32'd4);
    check("r27_ack_early", 32'(m0_ack), 32'd0);
    tick();
    check("r27_ack", 32'(m0_ack), 32'd1);
    check("r27_rd", m0_rd, 32'hDEAD_BEEF);
    m0_req = 1'b0;
    tick();

    // Lone m1 write.
    drive(1, 1'b1, 32'h0000_0008, 1'b1, 32'h1234_5678);
    tick();
    check("r28_we", 32'(mem_we), 32'd1);
    check("r28_addr", 32'(mem_addr), 32'd2);
    check("r28_wd", mem_wd, 32'h1234_5678);
    tick();
    check("r28_we_off", 32'(mem_we), 32'd0);
    check("r28_ack", 32'(m1_ack), 32'd1);
    check("r28_rd", m1_rd, 32'd0);
    m1_req = 1'b0;
    tick();

    // Both requesters held from reset: strict alternation, one ack per 3 cycles.
    drive(0, 1'b1, 32'h0000_0020, 1'b0, '0);
    drive(1, 1'b1, 32'h0000_0008, 1'b0, '0);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    ack_owner.delete();
    ack_cyc.delete();
    for (int k = 0; k < 12; k++) tick();
    check("r29_nacks", 32'(ack_owner.size()), 32'd4);
    for (int k = 0; k < 4 && k < ack_owner.size(); k++) begin
      check("r29_order", 32'(ack_owner[k]), 32'(k % 2));
      if (k > 0) check("r29_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();

    // Top-of-space address truncates to the last word.
    drive(0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    tick();
    check("r30_addr", 32'(mem_addr), 32'h3FF);
    tick();
    m0_req = 1'b0;
    tick();

    // Reset during ACC of an m0 write: transaction abandoned, next tie to m0.
    drive(0, 1'b1, 32'h0000_0100, 1'b1, 32'hA5A5_0001);
    tick();
    check("r31_we_acc", 32'(mem_we), 32'd1);
    resetn = 1'b1;
    m0_req = 1'b0;
    tick();
    check("r31_we_rst", 32'(mem_we), 32'd0);
    check("r31_no_ack", 32'(m0_ack | m1_ack), 32'd0);
    resetn = 1'b0;
    drive(0, 1'b1, 32'h0000_0100, 1'b0, '0);
    drive(1, 1'b1, 32'h0000_0200, 1'b0, '0);
    tick();
    check("r31_tie_m0", 32'(mem_addr), 32'h40);
    tick();
    check("r31_ack_m0", 32'(m0_ack), 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    tick();
    tick();

    // m1 drops req after grant; m0 arriving meanwhile goes next.
    drive(1, 1'b1, 32'h0000_0030, 1'b0, '0);
    tick();
    m1_req = 1'b0;
    drive(0, 1'b1, 32'h0000_0034, 1'b0, '0);
    tick();
    check("r32_m1_ack", 32'(m1_ack), 32'd1);
    tick();
    tick();
    check("r32_m0_addr", 32'(mem_addr), 32'd13);
    tick();
    check("r32_m0_ack", 32'(m0_ack), 32'd1);
    m0_req = 1'b0;
    tick();

    // Random traffic with early drops and occasional resets.
    st[0] = 0;
    st[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      resetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (ph == 2 && int'(m_owner) == i) begin
          st[i] = 0;
          drive(i, 1'b0, '0, 1'b0, '0);
        end
        if (st[i] == 1 && ph == 1 && int'(m_owner) == i && $urandom_range(0, 7) == 0) begin
          st[i] = 2;
          if (i == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
        if (st[i] == 0 && $urandom_range(0, 3) == 0) begin
          logic [31:0] a;
          a = $urandom;
          if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_003F;
          drive(i, 1'b1, a, 1'($urandom_range(0, 1)), $urandom);
          st[i] = 1;
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b1;
        st[0] = 0;
        st[1] = 0;
        drive(0, 1'b0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, 1'b0, '0);
      end
      tick();
      check("one_ack", 32'(m0_ack & m1_ack), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
